// File: rtl/traceback_alignment_builder.sv
// Turns traceback steps (walked from the far corner back to the origin) into aligned
// columns. Columns are stacked in a LIFO and streamed out in forward order.
module traceback_alignment_builder #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int CW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_valid,
    input  logic [2:0]         symbol,
    input  logic [CW-1:0]      a_char,
    input  logic [CW-1:0]      b_char,
    input  logic               end_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW:0]        out_a,
    output logic [CW:0]        out_b,
    output logic               out_last,
    output logic [BitAddr+1:0] align_len,
    output logic               busy,
    output logic               done,
    output logic               err_symbol,
    output logic               overflow
);
    localparam int AW = $clog2(2 * N);
    localparam int EW = 2 * (CW + 1);
    localparam logic [BitAddr+1:0] DEPTH    = (BitAddr + 2)'(2 * N);
    localparam logic [BitAddr+1:0] CNT_ONE  = (BitAddr + 2)'(1);
    localparam logic [CW:0]        GAP      = {1'b1, {CW{1'b0}}};
    localparam logic [2:0]         SYM_DIAG = 3'b001;
    localparam logic [2:0]         SYM_UP   = 3'b010;
    localparam logic [2:0]         SYM_LEFT = 3'b100;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t            state, state_next;
    logic [BitAddr+1:0] count;
    logic [EW-1:0]     lifo_mem [0:2*N-1];
    logic [AW-1:0]     top_idx;
    logic [EW-1:0]     top_entry;
    logic [CW:0]       push_a, push_b;
    logic              sym_legal;
    logic              step_take;
    logic              do_push;
    logic              pop;

    always_comb begin
        sym_legal = 1'b1;
        push_a    = '0;
        push_b    = '0;
        case (symbol)
            SYM_DIAG: begin
                push_a = {1'b0, a_char};
                push_b = {1'b0, b_char};
            end
            SYM_UP: begin
                push_a = {1'b0, a_char};
                push_b = GAP;
            end
            SYM_LEFT: begin
                push_a = GAP;
                push_b = {1'b0, b_char};
            end
            default: sym_legal = 1'b0;
        endcase
    end

    // A restart pulse overrides any step or pop presented in the same cycle.
    assign step_take = (state == COLLECT) && step_valid && !start;
    assign do_push   = step_take && sym_legal && (count != DEPTH);
    assign out_valid = (state == DRAIN) && (count != '0);
    assign pop       = out_valid && out_ready && !start;
    assign out_last  = out_valid && (count == CNT_ONE);
    assign busy      = (state == COLLECT) || (state == DRAIN);
    assign done      = (state == DONE);

    // Top of stack is entry count-1; wraps harmlessly when empty since output is gated.
    assign top_idx   = count[AW-1:0] - AW'(1);
    assign top_entry = lifo_mem[top_idx];
    assign out_a     = out_valid ? top_entry[EW-1:CW+1] : '0;
    assign out_b     = out_valid ? top_entry[CW:0]      : '0;

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = COLLECT;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                COLLECT: if (end_c) state_next = DRAIN;
                DRAIN:   if ((count == '0) || (pop && count == CNT_ONE)) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            align_len  <= '0;
            err_symbol <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                count      <= '0;
                align_len  <= '0;
                err_symbol <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (step_take && !sym_legal) err_symbol <= 1'b1;
                if (step_take && sym_legal && count == DEPTH) overflow <= 1'b1;
                if (do_push) begin
                    count <= count + CNT_ONE;
                    if (align_len != DEPTH) align_len <= align_len + CNT_ONE;
                end else if (pop) begin
                    count <= count - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) lifo_mem[count[AW-1:0]] <= {push_a, push_b};
    end
endmodule

// File: tb/tb_traceback_alignment_builder.sv
// Randomized and directed check of the alignment builder against a queue-based model
// of the column stack (push per legal step, emit in reverse order).
module tb_traceback_alignment_builder;
    localparam int N       = 4;
    localparam int BitAddr = $clog2(N + 1);
    localparam int CW      = 2;
    localparam int DEPTH   = 2 * N;
    localparam logic [CW:0] GAP = {1'b1, {CW{1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, step_valid = 1'b0, end_c = 1'b0, out_ready = 1'b0;
    logic [2:0]         symbol = '0;
    logic [CW-1:0]      a_char = '0, b_char = '0;
    logic               out_valid, out_last, busy, done, err_symbol, overflow;
    logic [CW:0]        out_a, out_b;
    logic [BitAddr+1:0] align_len;

    int total = 0;
    int bad   = 0;

    typedef struct {bit valid; logic [2:0] sym; logic [CW-1:0] a; logic [CW-1:0] b;} step_t;
    typedef struct {logic [CW:0] a; logic [CW:0] b;} col_t;

    step_t steps[$];
    col_t  mq[$];
    bit    me, mo;
    int    mlen;

    always #5 clk = ~clk;

    traceback_alignment_builder #(.N(N), .BitAddr(BitAddr), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .step_valid(step_valid), .symbol(symbol),
        .a_char(a_char), .b_char(b_char), .end_c(end_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_last(out_last),
        .align_len(align_len), .busy(busy), .done(done), .err_symbol(err_symbol),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_step(input bit v, input logic [2:0] s, input logic [CW-1:0] a,
                            input logic [CW-1:0] b);
        step_t st;
        st.valid = v; st.sym = s; st.a = a; st.b = b;
        steps.push_back(st);
    endtask

    // Model: each legal step yields one column; a full stack flags overflow instead.
    task automatic model_step(input step_t st);
        col_t c;
        bit   legal;
        legal = 1'b1;
        c.a = {1'b0, st.a};
        c.b = {1'b0, st.b};
        if (st.sym == 3'b010) c.b = GAP;
        else if (st.sym == 3'b100) c.a = GAP;
        else if (st.sym != 3'b001) legal = 1'b0;
        if (!legal) me = 1'b1;
        else if (mq.size() == DEPTH) mo = 1'b1;
        else mq.push_back(c);
    endtask

    task automatic collect(input bit end_with_last);
        mq.delete(); me = 1'b0; mo = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        foreach (steps[k]) begin
            step_valid = steps[k].valid;
            symbol     = steps[k].sym;
            a_char     = steps[k].a;
            b_char     = steps[k].b;
            end_c      = end_with_last && (k == steps.size() - 1);
            if (steps[k].valid) model_step(steps[k]);
            @(negedge clk);
        end
        step_valid = 1'b0;
        if (!end_with_last || steps.size() == 0) begin
            end_c = 1'b1;
            @(negedge clk);
        end
        end_c = 1'b0;
        mlen = mq.size();
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic drain(input string name, input int rmode);
        bit empty_seen = 1'b0;
        bit fin = 1'b0;
        int ph = 0;
        chk({name, ":busy"}, 32'(busy), 32'd1);
        chk({name, ":len"}, 32'(align_len), 32'(mlen));
        chk({name, ":err"}, 32'(err_symbol), 32'(me));
        chk({name, ":ovf"}, 32'(overflow), 32'(mo));
        for (int c = 0; c < 80; c++) begin
            if (empty_seen) begin
                chk({name, ":done"}, 32'(done), 32'd1);
                fin = 1'b1;
                break;
            end
            chk({name, ":done_early"}, 32'(done), 32'd0);
            chk({name, ":valid"}, 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk({name, ":out_a"}, 32'(out_a), 32'(mq[$].a));
                chk({name, ":out_b"}, 32'(out_b), 32'(mq[$].b));
                chk({name, ":last"}, 32'(out_last), 32'(mq.size() == 1));
                case (rmode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    default: out_ready = (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
                endcase
                ph++;
                if (out_ready) void'(mq.pop_back());
            end
            if (mq.size() == 0) empty_seen = 1'b1;
            @(negedge clk);
        end
        chk({name, ":finished"}, 32'(fin), 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, ":done_pulse"}, 32'(done), 32'd0);
        chk({name, ":idle"}, 32'(busy), 32'd0);
        chk({name, ":len_hold"}, 32'(align_len), 32'(mlen));
        $display("trace %s len=%0d err=%0d ovf=%0d", name, mlen, me, mo);
    endtask

    initial begin
        #2;
        chk("rst:valid", 32'(out_valid), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:len", 32'(align_len), 32'd0);
        chk("rst:flags", 32'({err_symbol, overflow, done, out_last}), 32'd0);
        chk("rst:out", 32'({out_a, out_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        steps.delete();
        add_step(1, 3'b001, 2'd0, 2'd1);
        add_step(1, 3'b001, 2'd2, 2'd2);
        add_step(1, 3'b010, 2'd3, 2'd1);
        collect(1'b0); drain("diag_diag_up", 0);

        steps.delete();
        add_step(1, 3'b100, 2'd0, 2'd2);
        collect(1'b1); drain("left_end", 0);

        steps.delete();
        add_step(1, 3'b001, 2'd1, 2'd3);
        add_step(1, 3'b100, 2'd0, 2'd0);
        add_step(1, 3'b010, 2'd2, 2'd1);
        add_step(1, 3'b001, 2'd3, 2'd2);
        collect(1'b0); drain("stall", 1);

        steps.delete();
        add_step(1, 3'b001, 2'd1, 2'd1);
        add_step(1, 3'b000, 2'd2, 2'd2);
        add_step(1, 3'b001, 2'd3, 2'd0);
        collect(1'b0); drain("illegal", 0);

        steps.delete();
        for (int k = 0; k < 9; k++) add_step(1, 3'b001, 2'(k), 2'(k + 1));
        collect(1'b0); drain("overflow", 2);

        steps.delete();
        collect(1'b0); drain("empty", 0);

        // Asynchronous reset in the middle of a drain.
        steps.delete();
        for (int k = 0; k < 5; k++) add_step(1, 3'b010, 2'(k), 2'd0);
        collect(1'b0);
        out_ready = 1'b1;
        chk("rstmid:pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid:valid", 32'(out_valid), 32'd0);
        chk("rstmid:busy", 32'(busy), 32'd0);
        chk("rstmid:len", 32'(align_len), 32'd0);
        chk("rstmid:out", 32'({out_a, out_b, out_last}), 32'd0);
        out_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        $display("trace reset_mid_drain");
        steps.delete();
        add_step(1, 3'b001, 2'd2, 2'd3);
        add_step(1, 3'b100, 2'd1, 2'd1);
        collect(1'b1); drain("after_reset", 0);

        for (int t = 0; t < 25; t++) begin
            int n, r;
            steps.delete();
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++) begin
                logic [2:0] s;
                r = $urandom_range(0, 9);
                s = (r < 3) ? 3'b001 : (r < 6) ? 3'b010 : (r < 9) ? 3'b100 : 3'($urandom_range(0, 7));
                add_step($urandom_range(0, 5) != 0, s, 2'($urandom), 2'($urandom));
            end
            collect(1'($urandom_range(0, 1)));
            drain($sformatf("rand%0d", t), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/traceback_alignment_builder.md
Name: traceback_alignment_builder

Overview:
- Sits directly downstream of the traceback direction counter.
- Each accepted traceback step (symbol plus the sequence characters at i_t-1, j_t-1) becomes one aligned column (char/char, char/gap, gap/char), pushed onto an internal LIFO.
- Traceback runs from (N-1,N-1) toward (0,0), so the LIFO is drained in forward order as a ready/valid stream of aligned columns.

Parameters:
N, 128, max sequence length; LIFO depth is 2*N.
BitAddr, $clog2(N+1), index width minus one (matches i_t/j_t width BitAddr+1).
CW, 2, character code width (nucleotide).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse: clear LIFO and flags, enter COLLECT.
step_valid  in  1  one traceback step presented this cycle.
symbol  in  3  direction: UP=3'b010, LEFT=3'b100, DIAG=3'b001.
a_char  in  CW  sequence-A character at row i_t-1, aligned with step_valid.
b_char  in  CW  sequence-B character at column j_t-1, aligned with step_valid.
end_c  in  1  traceback reached (0,0).
out_valid  out  1  aligned column available.
out_ready  in  1  consumer accepts column.
out_a  out  CW+1  {gap_flag, char} for sequence A; gap = {1'b1, {CW{1'b0}}}.
out_b  out  CW+1  same encoding for sequence B.
out_last  out  1  current column is the final one.
align_len  out  BitAddr+2  number of columns collected; held until next start.
busy  out  1  state is COLLECT or DRAIN.
done  out  1  one-cycle pulse when drain completes.
err_symbol  out  1  sticky: step_valid seen with an illegal symbol.
overflow  out  1  sticky: push attempted with LIFO full.

Behaviour:
- Reset (rst=0, async): state IDLE; LIFO count=0; out_valid=0, out_last=0, done=0, busy=0, err_symbol=0, overflow=0, align_len=0. out_a/out_b=0. Reset mid-operation discards all contents.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE: start -> COLLECT.
  - COLLECT: end_c sampled high -> DRAIN.
  - DRAIN: pop of the last entry, or count=0 on entry -> DONE.
  - DONE: single cycle with done=1 -> IDLE.
- start in any non-IDLE state: synchronous restart. Clear count, align_len and sticky flags; go to COLLECT. Any step_valid in that same cycle is ignored.
- COLLECT push rules, applied on a clock edge with step_valid=1:
  - DIAG -> push {0,a_char},{0,b_char}.
  - UP -> push {0,a_char},GAP.
  - LEFT -> push GAP,{0,b_char}.
  - Any other symbol -> no push, err_symbol<=1.
- Push increments count and align_len. If count==2N, no push and overflow<=1. align_len saturates at 2N.
- step_valid and end_c in the same cycle: the push happens first, then the move to DRAIN. Inputs are ignored outside COLLECT.
- DRAIN:
  - out_valid = (count!=0).
  - out_a/out_b = LIFO top entry (entry count-1), read combinationally from the registered count, with no bubble between pops.
  - out_last = out_valid && count==1.
  - Pop on out_valid && out_ready. out_a/out_b stay stable while out_valid=1 and out_ready=0.
- Order: the first column emitted is the last one pushed, i.e. the column nearest (0,0).
- Empty drain (end_c with nothing pushed): out_valid never rises. DRAIN->DONE the next cycle, done pulses, align_len=0.
- Outputs outside DRAIN: out_valid=0, out_last=0.
- Widths: count is BitAddr+2 bits to hold 2N. All index arithmetic is unsigned.

Test Plan:
- DIAG,DIAG,UP with (a,b)=(0,1),(2,2),(3,x), then end_c, out_ready=1 -> columns out in order (3,GAP),(2,2),(0,1). out_last on the third column, align_len=3, done one cycle after the last pop.
- LEFT step with b=2 and end_c in the same cycle -> single column (GAP,2) with out_last=1, align_len=1.
- Drain with out_ready toggled 1,0,0,1 -> no column lost or duplicated. Data held stable during stalls; a 4-column result takes exactly 4 handshakes.
- step_valid with symbol=3'b000 between two DIAGs -> err_symbol=1 sticky, align_len=2, two columns output.
- N=4: 9 valid steps -> overflow=1 after the 9th step, align_len=8, 8 columns drained.
- rst low mid-DRAIN -> outputs return to reset values immediately. After start, a new traceback produces a correct result with no stale entries.
